// File: rtl/uart_rx_engine_if.sv
// Read-side handshake between uart_rx_engine and the core register/interrupt
// logic. The engine drives the received byte and status flags; the core
// returns a one-cycle read strobe.
interface uart_rx_engine_if;
  logic       i_READ;
  logic [7:0] o_DATA;
  logic       o_RDY;
  logic       o_PERR;
  logic       o_FERR;
  logic       o_OVF;

  // Engine side: presents byte and status, consumes the read strobe
  modport master (
    input  i_READ,
    output o_DATA,
    output o_RDY,
    output o_PERR,
    output o_FERR,
    output o_OVF
  );

  // Core side: observes byte and status, issues the read strobe
  modport slave (
    output i_READ,
    input  o_DATA,
    input  o_RDY,
    input  o_PERR,
    input  o_FERR,
    input  o_OVF
  );
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: serial receive engine fed from the TSI RX pad path.
// Recovers 7/8-bit frames with optional parity using switch-selected baud,
// and holds each byte plus PERR/FERR/OVF status until the core reads it.
// Optional feature macro RX_MAJORITY_EN: each bit is resolved by a 2-of-3
// vote over the samples at terminal count -1, 0 and +1 (decision one cycle
// later). Without it a single sample at terminal count is used.
module uart_rx_engine #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CLK_HZ      = 100_000_000
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              i_RX,
  input  logic [3:0]        SW_BAUD,
  input  logic              SW_EIGHT,
  input  logic              SW_PEN,
  input  logic              SW_OHEL,
  uart_rx_engine_if.master  rx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Bit time in clocks for a baud code, rounded to nearest
  function automatic logic [31:0] f_bit_time(input logic [3:0] code);
    int unsigned baud;
    case (code)
      4'd0:    baud = 300;
      4'd1:    baud = 1200;
      4'd2:    baud = 2400;
      4'd3:    baud = 4800;
      4'd4:    baud = 9600;
      4'd5:    baud = 19200;
      4'd6:    baud = 38400;
      4'd7:    baud = 57600;
      4'd8:    baud = 115200;
      4'd9:    baud = 230400;
      4'd10:   baud = 460800;
      default: baud = 921600;
    endcase
    return (CLK_HZ + baud / 2) / baud;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d1;
  logic                   w_rx;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_bt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_eight;
  logic        r_pen;
  logic        r_odd;
  logic        r_armed;
  logic        r_perr_acc;

  logic [7:0]  r_data;
  logic        r_rdy;
  logic        r_perr;
  logic        r_ferr;
  logic        r_ovf;

  logic [31:0] w_bt_new;
  logic        w_tc;
  logic        w_fall;
  logic        w_bit_ev;
  logic        w_bit_val;
  logic        w_last;
  logic [7:0]  w_frame_data;

  assign w_rx     = r_sync[SYNC_STAGES-1];
  assign w_bt_new = f_bit_time(SW_BAUD);
  assign w_tc     = (r_state != S_IDLE) && (r_cnt == '0);
  assign w_fall   = r_armed && r_rx_d1 && !w_rx;
  assign w_last   = r_eight ? (r_idx == 3'd7) : (r_idx == 3'd6);
  // In 7-bit mode the seven LSB-first shifts leave the byte in [7:1]
  assign w_frame_data = r_eight ? r_shift : {1'b0, r_shift[7:1]};

`ifdef RX_MAJORITY_EN
  logic r_rx_d2;
  logic r_pend;

  // Vote history: second-previous synchronized sample and pending-decision flag
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_rx_d2 <= 1'b1;
      r_pend  <= 1'b0;
    end else begin
      r_rx_d2 <= r_rx_d1;
      r_pend  <= w_tc;
    end
  end

  // Decision one cycle after terminal count, over samples tc-1, tc, tc+1
  assign w_bit_ev  = r_pend;
  assign w_bit_val = (w_rx & r_rx_d1) | (w_rx & r_rx_d2) | (r_rx_d1 & r_rx_d2);
`else
  assign w_bit_ev  = w_tc;
  assign w_bit_val = w_rx;
`endif

  // Metastability synchronizer plus one-cycle history for edge detection
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_sync  <= '1;
      r_rx_d1 <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_RX};
      r_rx_d1 <= w_rx;
    end
  end

  // Frame FSM, bit-time counter and registered read-side outputs
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bt       <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_eight    <= 1'b0;
      r_pen      <= 1'b0;
      r_odd      <= 1'b0;
      r_armed    <= 1'b1;
      r_perr_acc <= 1'b0;
      r_data     <= '0;
      r_rdy      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        r_cnt <= w_tc ? (r_bt - 32'd1) : (r_cnt - 32'd1);
      end

      // A read strobe only clears status; completion below overrides it
      if (rx_if.i_READ && r_rdy) begin
        r_rdy <= 1'b0;
        r_ovf <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_armed && w_rx) begin
            r_armed <= 1'b1;
          end
          if (w_fall) begin
            r_bt       <= w_bt_new;
            r_cnt      <= (w_bt_new >> 1) - 32'd1;
            r_eight    <= SW_EIGHT;
            r_pen      <= SW_PEN;
            r_odd      <= SW_OHEL;
            r_perr_acc <= 1'b0;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_bit_ev) begin
            if (!w_bit_val) begin
              r_idx   <= '0;
              r_shift <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (w_bit_ev) begin
            r_shift <= {w_bit_val, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (w_last) begin
              r_state <= r_pen ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (w_bit_ev) begin
            r_perr_acc <= (^w_frame_data) ^ w_bit_val ^ r_odd;
            r_state    <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_bit_ev) begin
            r_data  <= w_frame_data;
            r_perr  <= r_perr_acc;
            r_ferr  <= !w_bit_val;
            r_rdy   <= 1'b1;
            r_ovf   <= r_rdy && !rx_if.i_READ;
            r_armed <= w_bit_val;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_if.o_DATA = r_data;
  assign rx_if.o_RDY  = r_rdy;
  assign rx_if.o_PERR = r_perr;
  assign rx_if.o_FERR = r_ferr;
  assign rx_if.o_OVF  = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: frames are serialised by a line
// driver, the expected read-side word is queued when each frame starts, and
// a monitor pops and compares whenever the engine presents a new byte.
module tb_uart_rx_engine;

  localparam int unsigned CLK_HZ = 12_000_000;
  localparam int unsigned SYNC   = 2;
`ifdef RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [3:0] sw_baud;
  logic       sw_eight, sw_pen, sw_ohel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_target = -1;
  int ev_count = 0;
  int last_ev_cyc = 0;
  logic auto_read = 1'b0;
  logic [11:0] sb[$];

  uart_rx_engine_if rx_if ();

  uart_rx_engine #(.SYNC_STAGES(SYNC), .CLK_HZ(CLK_HZ)) dut (
    .SYS_CLK (clk),
    .SYS_RST (rst_n),
    .i_RX    (rx),
    .SW_BAUD (sw_baud),
    .SW_EIGHT(sw_eight),
    .SW_PEN  (sw_pen),
    .SW_OHEL (sw_ohel),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: bit time from the nominal baud table, rounded to nearest
  function automatic int bt_of(input logic [3:0] code);
    int bauds[12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                      115200, 230400, 460800, 921600};
    int b;
    b = (code > 4'd11) ? 921600 : bauds[code];
    return int'(real'(CLK_HZ) / real'(b));
  endfunction

  // Parity bit value that makes the frame correct for the chosen sense
  function automatic logic good_parity(input logic [7:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return odd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Expected {rdy, ovf, perr, ferr, data} for a delivered frame
  function automatic logic [11:0] expect_word(input logic [7:0] d, input logic pen,
      input logic odd, input logic pbit, input logic stopb, input logic ovf);
    int total;
    logic perr;
    total = $countones(d) + int'(pbit);
    perr  = pen && (odd ? (total % 2 == 0) : (total % 2 == 1));
    return {1'b1, ovf, perr, !stopb, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_word();
    return {rx_if.o_RDY, rx_if.o_OVF, rx_if.o_PERR, rx_if.o_FERR, rx_if.o_DATA};
  endfunction

  // Pops an expectation whenever a byte is newly presented
  task automatic monitor_loop();
    logic [11:0] prev, cur;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_word();
      if (cur[11] && (!prev[11] || cur != prev)) begin
        ev_count++;
        last_ev_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected no output", cur);
        end else begin
          chk("frame", 32'(cur), 32'(sb.pop_front()));
        end
      end
      prev = cur;
    end
  endtask

  // Sole driver of the read strobe: auto-consume or one scheduled cycle
  task automatic reader_loop();
    forever begin
      @(negedge clk);
      rx_if.i_READ = (auto_read && rx_if.o_RDY) || (cyc == rd_target);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nb, input logic pen,
      input logic odd, input logic pbit, input logic stopb, input logic [3:0] code,
      input logic ovf, input int extra_low, input int spike_bit,
      input logic coincide, input logic scramble, output int c0);
    logic bits[$];
    logic [7:0] dm;
    int bt;
    bt = bt_of(code);
    dm = (nb == 8) ? data : {1'b0, data[6:0]};
    bits.push_back(1'b0);
    for (int k = 0; k < nb; k++) bits.push_back(dm[k]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stopb);
    @(negedge clk);
    sw_baud = code; sw_eight = (nb == 8); sw_pen = pen; sw_ohel = odd;
    c0 = cyc;
    sb.push_back(expect_word(dm, pen, odd, pbit, stopb, ovf));
    if (coincide)
      rd_target = c0 + int'(SYNC) + bt / 2 + (nb + int'(pen) + 1) * bt + MAJ;
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 0; j < bt; j++) begin
        if (!(b == 0 && j == 0)) @(negedge clk);
        rx = bits[b] ^ ((b == spike_bit) && (j == bt / 2));
        if (scramble && b == 1 && j == 0)
          {sw_baud, sw_eight, sw_pen, sw_ohel} = 7'($urandom);
      end
    end
    repeat (extra_low) @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic request_read();
    @(negedge clk);
    rd_target = cyc + 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic main_seq();
    int c0, bt, nb, evs;
    logic [7:0] d;
    logic pen, odd, pb, sb_stop;
    logic [3:0] code;

    rst_n = 1'b0; rx = 1'b1; sw_baud = '0; sw_eight = 1'b1; sw_pen = 1'b0; sw_ohel = 1'b0;
    rx_if.i_READ = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs", 32'(dut_word()), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 9600 8N1 0xA5, held unread; check latency to o_RDY
    bt = bt_of(4'd4);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 0, -1, 1'b0, 1'b0, c0);
    repeat (4) @(negedge clk);
    chk("latency_9600", 32'(last_ev_cyc - c0),
        32'(int'(SYNC) + bt / 2 + 9 * bt + 1 + MAJ));
    chk("rdy_held", 32'(rx_if.o_RDY), 32'h1);
    request_read();
    chk("rdy_after_read", 32'(rx_if.o_RDY), 32'h0);

    // 115200 7E1 / 7O1 with parity bit 1
    auto_read = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 0, -1, 1'b0, 1'b1, c0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 1'b0, 0, -1, 1'b0, 1'b1, c0);
    repeat (8) @(negedge clk);

    // Back-to-back unread frames produce overflow
    auto_read = 1'b0;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, -1, 1'b0, 1'b0, c0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 0, -1, 1'b0, 1'b0, c0);
    repeat (8) @(negedge clk);
    request_read();
    chk("ovf_read_word", 32'(dut_word()), 32'h034);

    // Stop bit 0 followed by a 3-bit-time break, then a clean 0x55
    auto_read = 1'b1;
    bt = bt_of(4'd8);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 3 * bt, -1, 1'b0, 1'b0, c0);
    evs = ev_count;
    repeat (2 * bt) @(negedge clk);
    chk("no_frame_in_break", 32'(ev_count), 32'(evs));
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, -1, 1'b0, 1'b0, c0);
    repeat (8) @(negedge clk);

    // 0.3 BT glitch on idle line is rejected
    evs = ev_count;
    @(negedge clk);
    rx = 1'b0;
    repeat (bt * 3 / 10) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bt) @(negedge clk);
    chk("glitch_no_event", 32'(ev_count), 32'(evs));
    chk("glitch_rdy", 32'(rx_if.o_RDY), 32'h0);
`ifdef RX_MAJORITY_EN
    send_frame(8'h6B, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, 4, 1'b0, 1'b0, c0);
    send_frame(8'h94, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, 7, 1'b0, 1'b0, c0);
    repeat (8) @(negedge clk);
`endif

    // Reset mid-DATA with a byte held, then fresh frame and coincident read
    auto_read = 1'b0;
    send_frame(8'hE7, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, -1, 1'b0, 1'b0, c0);
    @(negedge clk);
    rx = 1'b0;
    repeat (bt) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bt) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_frame", 32'(dut_word()), 32'h0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, -1, 1'b0, 1'b0, c0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 0, -1, 1'b1, 1'b0, c0);
    repeat (4) @(negedge clk);
    chk("coincident_read_word", 32'(dut_word()), 32'h85A);
    request_read();
    chk("rdy_cleared", 32'(rx_if.o_RDY), 32'h0);

    // Randomised frames at the faster baud codes
    auto_read = 1'b1;
    for (int n = 0; n < 30; n++) begin
      code    = 4'(8 + $urandom_range(0, 7));
      nb      = ($urandom_range(0, 1) == 1) ? 8 : 7;
      pen     = 1'($urandom_range(0, 1));
      odd     = 1'($urandom_range(0, 1));
      d       = 8'($urandom);
      pb      = good_parity((nb == 8) ? d : {1'b0, d[6:0]}, odd) ^ ($urandom_range(0, 3) == 0);
      sb_stop = ($urandom_range(0, 7) != 0);
      send_frame(d, nb, pen, odd, pb, sb_stop, code, 1'b0, 0, -1, 1'b0, 1'b1, c0);
      repeat ($urandom_range(1, bt_of(code))) @(negedge clk);
    end

    repeat (4 * bt) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    fork
      monitor_loop();
      reader_loop();
      main_seq();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Serial receive engine inside the SOPC core, directly downstream of the TSI RX pad path. It takes the raw RX line from TSI, recovers frames using the same switch-selected baud, bit-length and parity controls the transmitter uses, and presents each byte with status flags through a ready/read-strobe handshake to the core's register/interrupt logic.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the i_RX metastability synchronizer (minimum 2)
CLK_HZ, 100000000, system clock frequency; bit-time counts are derived from it

Ports:
SYS_CLK  in  1  system clock
SYS_RST  in  1  reset; asynchronous, active-low
i_RX  in  1  raw serial line from TSI (idle high)
SW_BAUD  in  4  baud select
SW_EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
SW_PEN  in  1  1 = parity bit present
SW_OHEL  in  1  1 = odd parity, 0 = even parity
i_READ  in  1  one-cycle strobe from the core: current byte consumed
o_DATA  out  8  received byte; bit 7 = 0 in 7-bit mode
o_RDY  out  1  byte available
o_PERR  out  1  parity error on the held byte
o_FERR  out  1  framing error (stop bit sampled 0) on the held byte
o_OVF  out  1  a byte completed while o_RDY was still 1

Behaviour:
- Reset (SYS_RST low, any time, including mid-frame): all outputs 0, FSM to IDLE, counters 0, synchronizer flops preset to 1. Release takes effect on the next clock edge.
- i_RX passes through SYNC_STAGES flops; all sampling uses the synchronized value.
- Bit time BT = CLK_HZ / baud, rounded to nearest. SW_BAUD 0..11 = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600. Codes 12..15 = 921600. At 100 MHz: 9600 gives BT = 10417; 115200 gives BT = 868.
- Latched at start detection and held for the frame: SW_BAUD, SW_EIGHT, SW_PEN, SW_OHEL. Switch changes mid-frame apply only to the next frame.
- FSM:
  - IDLE: wait for a synchronized 1→0 edge while armed. Then latch config, load counter with BT/2, go to START.
  - START: at terminal count, sample the line.
    - 0: load BT, bit index 0, go to DATA.
    - 1 (glitch): go to IDLE with no output change.
  - DATA: sample at each BT terminal count, shifting LSB first. After bit 6 (7-bit mode) or bit 7 (8-bit mode), go to PARITY if PEN is set, otherwise STOP.
  - PARITY: sample one bit.
    - Error when odd mode and (data XOR parity bit) = 0.
    - Error when even mode and (data XOR parity bit) = 1.
    - Parity is computed over 7 or 8 data bits, per the latched mode.
  - STOP: sample one bit, then complete the frame and go to IDLE. A stop bit of 0 sets FERR and disarms IDLE until the line has been sampled 1 for at least one cycle (break protection).
- Completion, one cycle after the stop-bit sample:
  - o_DATA, o_PERR, o_FERR loaded; o_RDY = 1.
  - o_OVF = 1 if o_RDY was already 1; otherwise o_OVF = 0.
  - The byte is delivered even when FERR or PERR is set.
- i_READ with o_RDY = 1: next cycle o_RDY = 0 and o_OVF = 0. o_DATA, o_PERR, o_FERR hold their values.
- i_READ with o_RDY = 0: ignored.
- i_READ in the same cycle as completion: completion wins. o_RDY stays 1, the new data is loaded, o_OVF = 0 (the old byte is deemed read).
- Sample point is mid-bit. With the synchronizer, latency from the line edge to the sample is BT/2 + SYNC_STAGES cycles.

Optional Feature:
Macro RX_MAJORITY_EN.
- Defined: each bit (start, data, parity, stop) is resolved by 2-of-3 majority of samples at terminal count −1, terminal count and terminal count +1. The bit decision moves one cycle later; completion is still one cycle after the stop decision.
- Not defined: single sample at terminal count. Vote logic is absent.

Test Plan:
1. 9600 baud (SW_BAUD=4), 8N1, byte 0xA5, no i_READ → o_DATA=0xA5, o_RDY=1, PERR=FERR=OVF=0; o_RDY rises about 9.5×10417 cycles after the start edge.
2. 115200 baud (SW_BAUD=8), 7 data bits, even parity, 0x41 sent with parity bit 1 → o_DATA=0x41, PERR=1. Repeat with odd parity (SW_OHEL=1) → PERR=0.
3. Two back-to-back 8N1 frames 0x12 then 0x34, no i_READ → second completion gives o_DATA=0x34, OVF=1. Pulse i_READ → o_RDY=0, OVF=0, o_DATA remains 0x34.
4. Frame with stop bit forced 0, then line held low for 3 bit times → FERR=1, o_RDY=1. No new frame is detected until the line returns high; the next valid 0x55 is received cleanly.
5. 0.3·BT low glitch on an idle line → no o_RDY, FSM returns to IDLE. With RX_MAJORITY_EN defined, a 1-cycle spike injected at a data-bit mid-point → correct byte.
6. SYS_RST driven low mid-DATA of a frame → all outputs 0 immediately. After release, a fresh 0xC3 frame is received correctly. i_READ coincident with completion → o_RDY stays 1, OVF=0.
